// File: rtl/key_conditioner.sv
// Per-channel button conditioner: two-flop synchroniser, stable-count debounce,
// press/release pulses, long-press level and optional auto-repeat pulses.
module key_conditioner #(
  parameter int unsigned     N             = 5,
  parameter int unsigned     DB_CYCLES     = 16,
  parameter int unsigned     HOLD_CYCLES   = 500,
  parameter int unsigned     REPEAT_CYCLES = 100,
  parameter logic [N-1:0]    REPEAT_EN     = '0,
  parameter int unsigned     CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_press_o,
  output logic [N-1:0] repeat_pulse_o,
  output logic         any_press_o
);

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);

  logic [N-1:0]     s1_q, s2_q;
  logic [N-1:0]     level_q, level_d;
  logic [N-1:0]     press_q, press_d;
  logic [N-1:0]     release_q, release_d;
  logic [N-1:0]     long_q, long_d;
  logic [N-1:0]     rep_pulse_q, rep_pulse_d;
  logic             any_q;
  logic [N-1:0]     rise, fall;
  state_e           st_q   [N];
  state_e           st_d   [N];
  logic [CNT_W-1:0] db_q   [N];
  logic [CNT_W-1:0] db_d   [N];
  logic [CNT_W-1:0] hold_q [N];
  logic [CNT_W-1:0] hold_d [N];
  logic [CNT_W-1:0] rep_q  [N];
  logic [CNT_W-1:0] rep_d  [N];

  always_comb begin
    level_d     = level_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = long_q;
    rep_pulse_d = '0;
    rise        = '0;
    fall        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      st_d[i]   = st_q[i];
      db_d[i]   = db_q[i];
      hold_d[i] = hold_q[i];
      rep_d[i]  = rep_q[i];

      if (s2_q[i] != level_q[i]) begin
        if (db_q[i] == DB_MAX) begin
          level_d[i] = ~level_q[i];
          db_d[i]    = '0;
          rise[i]    = ~level_q[i];
          fall[i]    = level_q[i];
        end else begin
          db_d[i] = db_q[i] + 1'b1;
        end
      end else begin
        db_d[i] = '0;
      end
      press_d[i]   = rise[i];
      release_d[i] = fall[i];

      case (st_q[i])
        IDLE: begin
          if (rise[i]) begin
            st_d[i]   = HELD;
            hold_d[i] = '0;
          end
        end
        HELD: begin
          hold_d[i] = hold_q[i] + 1'b1;
          if (hold_q[i] == HOLD_MAX) begin
            st_d[i]        = LONG;
            long_d[i]      = 1'b1;
            rep_pulse_d[i] = REPEAT_EN[i];
            rep_d[i]       = '0;
          end
        end
        LONG: begin
          if (REPEAT_EN[i]) begin
            if (rep_q[i] == REP_MAX) begin
              rep_pulse_d[i] = 1'b1;
              rep_d[i]       = '0;
            end else begin
              rep_d[i] = rep_q[i] + 1'b1;
            end
          end
        end
        default: st_d[i] = IDLE;
      endcase

      // Release overrides whatever the hold/repeat logic decided this edge.
      if (fall[i]) begin
        st_d[i]        = IDLE;
        long_d[i]      = 1'b0;
        hold_d[i]      = '0;
        rep_d[i]       = '0;
        rep_pulse_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      rep_pulse_q <= '0;
      any_q       <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        st_q[i]   <= IDLE;
        db_q[i]   <= '0;
        hold_q[i] <= '0;
        rep_q[i]  <= '0;
      end
    end else begin
      s1_q        <= btn_in_i;
      s2_q        <= s1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      rep_pulse_q <= rep_pulse_d;
      any_q       <= |press_d;
      for (int unsigned i = 0; i < N; i++) begin
        st_q[i]   <= st_d[i];
        db_q[i]   <= db_d[i];
        hold_q[i] <= hold_d[i];
        rep_q[i]  <= rep_d[i];
      end
    end
  end

  assign level_o        = level_q;
  assign press_o        = press_q;
  assign release_o      = release_q;
  assign long_press_o   = long_q;
  assign repeat_pulse_o = rep_pulse_q;
  assign any_press_o    = any_q;

endmodule
